dm_arbiter: RTL and testbench
=============================

DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32: byte-address width of both requester ports and the memory port.
REQ-002 Parameter DATA_W, default 32: word width.
REQ-003 Parameter MAX_BURST, default 4: maximum consecutive accesses granted to one port while the other port waits.
REQ-004 clk  in  1: single clock; all state updates on the rising edge.
REQ-005 reset  in  1: synchronous, active-high reset.
REQ-006 rN_req  in  1 (N=0,1): access request; held with its fields stable until rN_ack.
REQ-007 rN_we  in  1: 1 = store, 0 = load.
REQ-008 rN_addr  in  ADDR_W: byte address.
REQ-009 rN_wdata  in  DATA_W: store data.
REQ-010 rN_pc  in  32: PC of the issuing instruction, used only for trace.
REQ-011 rN_ack  out  1: access performed this cycle; a store commits at the next edge and a load's data is valid now.
REQ-012 rN_rdata  out  DATA_W: load data, driven from m_rdata.
REQ-013 m_addr/m_wdata/m_we  out  ADDR_W/DATA_W/1: single-port memory command.
REQ-014 m_rdata  in  DATA_W: combinational read data from memory.

Function
REQ-015 FSM states: IDLE, OWN0, OWN1, held in registers; the owner is the only port whose fields drive m_*.
REQ-016 In OWNn with rn_req=1, the block drives m_* from port n, sets rn_ack=1, and increments the burst counter; other acks are 0.
REQ-017 In IDLE, or in OWNn with rn_req=0, all acks and m_we are 0, and m_addr/m_wdata hold their last value.
REQ-018 IDLE transitions:
  - one request pending: go to that port's OWN state;
  - both pending: go to the port not served last (round-robin pointer);
  - none pending: stay.
  Grant latency from IDLE is exactly 1 cycle.
REQ-019 OWNn stays in OWNn while rn_req=1 and (burst count < MAX_BURST or the other port is idle), giving one access per cycle.
REQ-020 OWNn releases when rn_req=0 or (count == MAX_BURST and other req=1):
  - to OWN(other) if the other port is requesting;
  - else to IDLE.
  The pointer records n, and the count clears on every ownership change.
REQ-021 When a burst limit forces a switch, the access acked in the final counted cycle completes normally; the preempted port's still-held request is served later.
REQ-022 The burst counter saturates at MAX_BURST when the other port is idle and never wraps.
REQ-023 m_we SHALL never be 1 unless exactly one rn_ack is 1 in the same cycle.
REQ-024 rN_rdata SHALL equal m_rdata for both ports; its contents are meaningful only when rN_ack=1.

Reset
REQ-025 While reset=1 at an edge:
  - state goes to IDLE, the pointer to 1 (port 0 wins the first tie), and the count to 0;
  - the cycle after, acks=0, m_we=0, m_addr=0, m_wdata=0.
REQ-026 Reset asserted mid-burst drops the in-progress ownership, performs no write in the reset cycle, and leaves the requester to re-arbitrate after reset.

Configuration
REQ-027 Macro DM_ARB_TRACE_EN defined: each committed store prints "@<pc-8>: *<addr> <= <wdata>" (hex, 8 digits) at the commit edge, using the owning port's rn_pc.
REQ-028 Macro DM_ARB_TRACE_EN undefined: no display statements are compiled; port behaviour is identical.

Structure
REQ-029 Package dm_arb_pkg holds the FSM state type (IDLE/OWN0/OWN1) and port-index constants PORT0/PORT1.
REQ-030 Sub-module dm_arb_rr_pick (two-way round-robin picker: req[1:0] and last-served pointer in, winner and valid out) is instantiated once and used for every IDLE and release decision.

Verification
REQ-031 Reset, then r0 store (addr 0x10, data 0xDEADBEEF) alone -> r0_ack one cycle later, m_we=1, m_addr=0x10; later r1 load of 0x10 returns 0xDEADBEEF.
REQ-032 r0 and r1 request in the same cycle straight after reset -> port 0 granted first; when r0 drops, r1 is acked the next cycle.
REQ-033 r0 holds req for 10 accesses, r1 pending from cycle 0, MAX_BURST=4 -> exactly 4 r0 acks, then r1 served, then r0 resumes; no cycle has two acks.
REQ-034 r0 requesting alone for 20 cycles -> 20 consecutive acks with no forced release; the counter stays at 4.
REQ-035 Reset asserted during an r1 store burst -> no m_we in the reset cycle, acks 0 the next cycle, and the first post-reset tie goes to port 0.
REQ-036 With DM_ARB_TRACE_EN, r0 store at pc 0x3008, addr 0x4, data 0x5 -> log line "@00003000: *00000004 <= 00000005"; without the macro, no output and identical waveforms.

Source files
------------

// File: rtl/dm_arb_pkg.sv
// Shared types for the two-port data-memory arbiter: FSM state encoding and
// port-index constants.
package dm_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } arb_state_e;

   localparam logic PORT0 = 1'b0;
   localparam logic PORT1 = 1'b1;

   function automatic arb_state_e own_state(input logic port);
      return (port == PORT1) ? OWN1 : OWN0;
   endfunction

endpackage

// File: rtl/dm_arb_rr_pick.sv
// Two-way round-robin picker: on a tie the port that was not served last wins.
module dm_arb_rr_pick
   import dm_arb_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last_served,
   output logic       winner,
   output logic       valid
);

   always_comb begin
      valid  = |req;
      winner = PORT0;
      if (req == 2'b11) begin
         winner = ~last_served;
      end else if (req[1]) begin
         winner = PORT1;
      end
   end

endmodule

// File: rtl/dm_arbiter.sv
// Two-port data-memory arbiter with round-robin ownership and a burst limit.
// Optional store trace is enabled by defining DM_ARB_TRACE_EN.
module dm_arbiter
   import dm_arb_pkg::*;
#(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int MAX_BURST = 4
) (
   input  logic              clk,
   input  logic              reset,

   input  logic              r0_req,
   input  logic              r0_we,
   input  logic [ADDR_W-1:0] r0_addr,
   input  logic [DATA_W-1:0] r0_wdata,
   input  logic [31:0]       r0_pc,
   output logic              r0_ack,
   output logic [DATA_W-1:0] r0_rdata,

   input  logic              r1_req,
   input  logic              r1_we,
   input  logic [ADDR_W-1:0] r1_addr,
   input  logic [DATA_W-1:0] r1_wdata,
   input  logic [31:0]       r1_pc,
   output logic              r1_ack,
   output logic [DATA_W-1:0] r1_rdata,

   output logic [ADDR_W-1:0] m_addr,
   output logic [DATA_W-1:0] m_wdata,
   output logic              m_we,
   input  logic [DATA_W-1:0] m_rdata
);

   localparam int CNT_W = $clog2(MAX_BURST + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

   arb_state_e        state_q, state_d;
   logic              ptr_q, ptr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;

   logic              owned;
   logic              own_port;
   logic              own_req;
   logic              other_req;
   logic              access;
   logic              limit_hit;
   logic [CNT_W-1:0]  cnt_inc;
   logic              sel_we;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;

   logic [1:0]        pick_req;
   logic              pick_last;
   logic              pick_winner;
   logic              pick_valid;

   // Resolve the owning port and the command it presents.
   always_comb begin
      owned     = (state_q != IDLE);
      own_port  = (state_q == OWN1) ? PORT1 : PORT0;
      own_req   = own_port ? r1_req   : r0_req;
      other_req = own_port ? r0_req   : r1_req;
      sel_we    = own_port ? r1_we    : r0_we;
      sel_addr  = own_port ? r1_addr  : r0_addr;
      sel_wdata = own_port ? r1_wdata : r0_wdata;
      access    = owned && own_req && !reset;
      cnt_inc   = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 1'b1;
      limit_hit = access && (cnt_inc == CNT_MAX) && other_req;
   end

   // In IDLE the picker arbitrates both ports; while owning, it only sees the
   // other port so a release hands over to it or falls back to IDLE.
   always_comb begin
      pick_req  = {r1_req, r0_req};
      pick_last = ptr_q;
      if (owned) begin
         pick_req  = own_port ? {1'b0, r0_req} : {r1_req, 1'b0};
         pick_last = own_port;
      end
   end

   dm_arb_rr_pick u_pick (
      .req         (pick_req),
      .last_served (pick_last),
      .winner      (pick_winner),
      .valid       (pick_valid)
   );

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;

      if (access) begin
         addr_d  = sel_addr;
         wdata_d = sel_wdata;
         cnt_d   = cnt_inc;
      end

      unique case (state_q)
         IDLE: begin
            if (pick_valid) begin
               state_d = own_state(pick_winner);
               cnt_d   = '0;
            end
         end
         OWN0, OWN1: begin
            if (!own_req || limit_hit) begin
               ptr_d   = own_port;
               cnt_d   = '0;
               state_d = pick_valid ? own_state(pick_winner) : IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         ptr_q   <= PORT1;
         cnt_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

   // Idle cycles replay the last command so the memory bus stays quiet.
   always_comb begin
      r0_ack   = access && (own_port == PORT0);
      r1_ack   = access && (own_port == PORT1);
      m_we     = access && sel_we;
      m_addr   = access ? sel_addr  : addr_q;
      m_wdata  = access ? sel_wdata : wdata_q;
      r0_rdata = m_rdata;
      r1_rdata = m_rdata;
   end

`ifdef DM_ARB_TRACE_EN
   logic [31:0] sel_pc;
   assign sel_pc = own_port ? r1_pc : r0_pc;

   always_ff @(posedge clk) begin
      if (!reset && m_we) begin
         $display("@%08h: *%08h <= %08h", sel_pc - 32'd8, m_addr, m_wdata);
      end
   end
`else
   logic unused_pc;
   assign unused_pc = ^{r0_pc, r1_pc};
`endif

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter with a small word memory behind the m_* port.
module tb_dm_arbiter;

   typedef struct packed {
      logic        req;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
   } port_cmd_t;

   localparam port_cmd_t NONE = '0;

   logic        clk = 1'b0;
   logic        reset;
   logic        r0_req, r0_we, r1_req, r1_we;
   logic [31:0] r0_addr, r0_wdata, r0_pc, r1_addr, r1_wdata, r1_pc;
   logic        r0_ack, r1_ack, m_we;
   logic [31:0] r0_rdata, r1_rdata, m_addr, m_wdata, m_rdata;

   logic [31:0] mem [0:255] = '{default: 32'h0};

   int tests_run    = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   dm_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_BURST(4)) dut (
      .clk      (clk),
      .reset    (reset),
      .r0_req   (r0_req),
      .r0_we    (r0_we),
      .r0_addr  (r0_addr),
      .r0_wdata (r0_wdata),
      .r0_pc    (r0_pc),
      .r0_ack   (r0_ack),
      .r0_rdata (r0_rdata),
      .r1_req   (r1_req),
      .r1_we    (r1_we),
      .r1_addr  (r1_addr),
      .r1_wdata (r1_wdata),
      .r1_pc    (r1_pc),
      .r1_ack   (r1_ack),
      .r1_rdata (r1_rdata),
      .m_addr   (m_addr),
      .m_wdata  (m_wdata),
      .m_we     (m_we),
      .m_rdata  (m_rdata)
   );

   // Combinational-read, clocked-write memory model.
   assign m_rdata = mem[m_addr[9:2]];
   always @(posedge clk) begin
      if (m_we) mem[m_addr[9:2]] <= m_wdata;
   end

   function automatic port_cmd_t ld(input logic [31:0] a);
      port_cmd_t c;
      c = '{req: 1'b1, we: 1'b0, addr: a, wdata: 32'h0};
      return c;
   endfunction

   function automatic port_cmd_t st(input logic [31:0] a, input logic [31:0] d);
      port_cmd_t c;
      c = '{req: 1'b1, we: 1'b1, addr: a, wdata: d};
      return c;
   endfunction

   // Drive one cycle of inputs at the falling edge; outputs settle 1 time unit later.
   task automatic applyStimulus(input logic rst, input port_cmd_t c0, input port_cmd_t c1);
      @(negedge clk);
      reset    = rst;
      r0_req   = c0.req;
      r0_we    = c0.we;
      r0_addr  = c0.addr;
      r0_wdata = c0.wdata;
      r1_req   = c1.req;
      r1_we    = c1.we;
      r1_addr  = c1.addr;
      r1_wdata = c1.wdata;
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      tests_run++;
      assert (observed === expected) else begin
         tests_failed++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic checkAcks(input string tag, input logic a0, input logic a1, input logic we);
      checkOutput(tag, 64'({r0_ack, r1_ack, m_we}), 64'({a0, a1, we}));
   endtask

   initial begin
      reset = 1'b1;
      r0_req = 1'b0; r0_we = 1'b0; r0_addr = '0; r0_wdata = '0; r0_pc = 32'h1000;
      r1_req = 1'b0; r1_we = 1'b0; r1_addr = '0; r1_wdata = '0; r1_pc = 32'h2000;
      repeat (2) @(posedge clk);

      // Reset state
      applyStimulus(1'b0, NONE, NONE);
      checkAcks("reset_acks", 1'b0, 1'b0, 1'b0);
      checkOutput("reset_maddr", 64'(m_addr), 64'h0);
      checkOutput("reset_mwdata", 64'(m_wdata), 64'h0);

      // Lone store, then load it back through port 1
      applyStimulus(1'b0, st(32'h10, 32'hDEADBEEF), NONE);
      checkAcks("st_latency", 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, st(32'h10, 32'hDEADBEEF), NONE);
      checkAcks("st_ack", 1'b1, 1'b0, 1'b1);
      checkOutput("st_maddr", 64'(m_addr), 64'h10);
      checkOutput("st_mwdata", 64'(m_wdata), 64'hDEADBEEF);
      applyStimulus(1'b0, NONE, NONE);
      checkAcks("st_release", 1'b0, 1'b0, 1'b0);
      checkOutput("st_hold_addr", 64'(m_addr), 64'h10);
      applyStimulus(1'b0, NONE, ld(32'h10));
      checkAcks("ld_latency", 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, NONE, ld(32'h10));
      checkAcks("ld_ack", 1'b0, 1'b1, 1'b0);
      checkOutput("ld_rdata", 64'(r1_rdata), 64'hDEADBEEF);
      applyStimulus(1'b0, NONE, NONE);
      checkAcks("ld_release", 1'b0, 1'b0, 1'b0);

      // Tie straight after reset goes to port 0
      applyStimulus(1'b1, NONE, NONE);
      applyStimulus(1'b0, ld(32'h20), ld(32'h24));
      checkAcks("tie_latency", 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, ld(32'h20), ld(32'h24));
      checkAcks("tie_p0_first", 1'b1, 1'b0, 1'b0);
      checkOutput("tie_maddr0", 64'(m_addr), 64'h20);
      applyStimulus(1'b0, NONE, ld(32'h24));
      checkAcks("tie_p0_drop", 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, NONE, ld(32'h24));
      checkAcks("tie_p1_ack", 1'b0, 1'b1, 1'b0);
      checkOutput("tie_maddr1", 64'(m_addr), 64'h24);
      applyStimulus(1'b0, NONE, NONE);
      checkAcks("tie_idle", 1'b0, 1'b0, 1'b0);

      // Burst limit: 4 port-0 accesses, then port 1, then port 0 resumes
      applyStimulus(1'b0, ld(32'h40), ld(32'h44));
      checkAcks("burst_latency", 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b0, ld(32'h40), ld(32'h44));
         checkAcks($sformatf("burst_r0_%0d", i), 1'b1, 1'b0, 1'b0);
      end
      applyStimulus(1'b0, ld(32'h40), ld(32'h44));
      checkAcks("burst_switch_r1", 1'b0, 1'b1, 1'b0);
      applyStimulus(1'b0, ld(32'h40), NONE);
      checkAcks("burst_r1_drop", 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 6; i++) begin
         applyStimulus(1'b0, ld(32'h40), NONE);
         checkAcks($sformatf("resume_r0_%0d", i), 1'b1, 1'b0, 1'b0);
      end
      applyStimulus(1'b0, NONE, NONE);
      checkAcks("burst_idle", 1'b0, 1'b0, 1'b0);

      // Solo port 0 never forced off; counter saturates rather than wrapping
      applyStimulus(1'b0, ld(32'h48), NONE);
      checkAcks("solo_latency", 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 22; i++) begin
         applyStimulus(1'b0, ld(32'h48), NONE);
         checkAcks($sformatf("solo_r0_%0d", i), 1'b1, 1'b0, 1'b0);
      end
      applyStimulus(1'b0, ld(32'h48), ld(32'h4C));
      checkAcks("solo_sat_last", 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, NONE, ld(32'h4C));
      checkAcks("solo_sat_switch", 1'b0, 1'b1, 1'b0);
      applyStimulus(1'b0, NONE, NONE);
      checkAcks("solo_idle", 1'b0, 1'b0, 1'b0);

      // Reset in the middle of a port-1 store burst
      applyStimulus(1'b0, NONE, st(32'h80, 32'h11111111));
      checkAcks("rb_latency", 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, NONE, st(32'h80, 32'h11111111));
      checkAcks("rb_st1", 1'b0, 1'b1, 1'b1);
      checkOutput("rb_st1_maddr", 64'(m_addr), 64'h80);
      applyStimulus(1'b0, NONE, st(32'h84, 32'h22222222));
      checkAcks("rb_st2", 1'b0, 1'b1, 1'b1);
      checkOutput("rb_st2_mwdata", 64'(m_wdata), 64'h22222222);
      applyStimulus(1'b1, NONE, st(32'h88, 32'h33333333));
      checkAcks("rb_reset_cycle", 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, ld(32'h88), ld(32'h84));
      checkAcks("rb_after", 1'b0, 1'b0, 1'b0);
      checkOutput("rb_after_maddr", 64'(m_addr), 64'h0);
      checkOutput("rb_after_mwdata", 64'(m_wdata), 64'h0);
      applyStimulus(1'b0, ld(32'h88), ld(32'h84));
      checkAcks("rb_tie_p0", 1'b1, 1'b0, 1'b0);
      checkOutput("rb_no_write", 64'(r0_rdata), 64'h0);
      applyStimulus(1'b0, NONE, ld(32'h84));
      checkAcks("rb_p0_drop", 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, NONE, ld(32'h84));
      checkAcks("rb_p1", 1'b0, 1'b1, 1'b0);
      checkOutput("rb_p1_rdata", 64'(r1_rdata), 64'h22222222);
      applyStimulus(1'b0, NONE, NONE);
      checkAcks("rb_idle", 1'b0, 1'b0, 1'b0);

      // Store with a trace-visible PC, then read it back
      r0_pc = 32'h3008;
      applyStimulus(1'b0, st(32'h4, 32'h5), NONE);
      checkAcks("tr_latency", 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, st(32'h4, 32'h5), NONE);
      checkAcks("tr_store", 1'b1, 1'b0, 1'b1);
      applyStimulus(1'b0, NONE, ld(32'h4));
      checkAcks("tr_release", 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, NONE, ld(32'h4));
      checkAcks("tr_load", 1'b0, 1'b1, 1'b0);
      checkOutput("tr_rdata", 64'(r1_rdata), 64'h5);
      applyStimulus(1'b0, NONE, NONE);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
